// File: rtl/tone_sched_pkg.sv
// Shared definitions for the tone scheduler: FSM/grant encoding and the
// preset values understood by the downstream tone generator.
package tone_sched_pkg;

    // State encoding doubles as the grant code driven to the outside world.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MELODY = 2'd1,
        ST_HORN   = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    localparam logic [1:0] GRANT_NONE   = 2'd0;
    localparam logic [1:0] GRANT_MELODY = 2'd1;
    localparam logic [1:0] GRANT_HORN   = 2'd2;
    localparam logic [1:0] GRANT_ALARM  = 2'd3;

    localparam int NOTE_W = 15;

    localparam logic [NOTE_W-1:0] NOTE_M3   = 15'h625F;
    localparam logic [NOTE_W-1:0] NOTE_M5   = 15'h6715;
    localparam logic [NOTE_W-1:0] NOTE_M6   = 15'h69CD;
    localparam logic [NOTE_W-1:0] NOTE_M7   = 15'h6C39;
    localparam logic [NOTE_W-1:0] NOTE_H1   = 15'h6D55;
    localparam logic [NOTE_W-1:0] NOTE_H2   = 15'h6F5F;
    localparam logic [NOTE_W-1:0] NOTE_H3   = 15'h712F;
    localparam logic [NOTE_W-1:0] NOTE_H5   = 15'h738A;
    localparam logic [NOTE_W-1:0] NOTE_REST = 15'h3FFF;

    // A rest entry keeps the beat but silences the generator.
    function automatic logic is_rest(input logic [NOTE_W-1:0] note);
        return note == NOTE_REST;
    endfunction

endpackage

// File: rtl/tone_sched_melody_rom.sv
// Combinational melody table: index in, tone-generator preset out.
// Indices at or beyond MEL_LEN read back as a rest.
module tone_sched_melody_rom
    import tone_sched_pkg::*;
#(
    parameter int MEL_LEN = 32,
    parameter int IW      = 5
) (
    input  logic [IW-1:0]     idx,
    output logic [NOTE_W-1:0] note
);

    localparam int TBL_LEN = 32;

    // Four phrases, each closed by a rest beat.
    localparam logic [NOTE_W-1:0] TBL [TBL_LEN] = '{
        NOTE_M5, NOTE_M6, NOTE_H1, NOTE_H2, NOTE_H3, NOTE_H2, NOTE_H1, NOTE_REST,
        NOTE_M5, NOTE_M6, NOTE_H1, NOTE_H1, NOTE_H2, NOTE_H3, NOTE_H5, NOTE_REST,
        NOTE_H5, NOTE_H3, NOTE_H2, NOTE_H1, NOTE_M7, NOTE_M6, NOTE_M5, NOTE_REST,
        NOTE_M3, NOTE_M5, NOTE_M6, NOTE_M7, NOTE_H1, NOTE_H2, NOTE_H1, NOTE_REST
    };

    always_comb begin
        note = NOTE_REST;
        for (int i = 0; i < TBL_LEN; i++) begin
            if ((i < MEL_LEN) && (int'(idx) == i)) begin
                note = TBL[i];
            end
        end
    end

endmodule

// File: rtl/tone_sched.sv
// Priority scheduler for the buzzer tone generator: alarm over horn over
// melody playback. All outputs are registered; grant mirrors the FSM state.
module tone_sched
    import tone_sched_pkg::*;
#(
    parameter int WIDE     = 15,
    parameter int BEAT_DIV = 10000000,
    parameter int MEL_LEN  = 32
) (
    input  logic            clk_50M,
    input  logic            rst,
    input  logic            alarm_req,
    input  logic            horn_req,
    input  logic            mel_start,
    input  logic            mel_stop,
    input  logic            mel_loop,
    output logic [WIDE-1:0] origin,
    output logic            tone_en,
    output logic [1:0]      grant,
    output logic            mel_busy,
    output logic            mel_done
);

    localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int IW    = (MEL_LEN > 1) ? $clog2(MEL_LEN) : 1;

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_DIV - 1);
    localparam logic [IW-1:0]    IDX_LAST  = IW'(MEL_LEN - 1);

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]     mel_idx_q,  mel_idx_d;
    logic              mel_busy_q, mel_busy_d;
    logic              mel_done_q, mel_done_d;
    logic              alarm_hi_q, alarm_hi_d;
    logic [WIDE-1:0]   origin_q,   origin_d;
    logic              tone_en_q,  tone_en_d;

    logic              beat_tick;
    logic [NOTE_W-1:0] mel_note;

    assign beat_tick = (beat_cnt_q == BEAT_LAST);

    // The table is addressed with the next index so origin lands in the
    // same cycle as the index it belongs to.
    tone_sched_melody_rom #(
        .MEL_LEN (MEL_LEN),
        .IW      (IW)
    ) u_melody_rom (
        .idx  (mel_idx_d),
        .note (mel_note)
    );

    // Melody bookkeeping: the index only moves while the melody owns the
    // generator, which is what freezes it during preemption.
    always_comb begin
        mel_busy_d = mel_busy_q;
        mel_idx_d  = mel_idx_q;
        mel_done_d = 1'b0;

        if ((state_q == ST_MELODY) && beat_tick) begin
            if (mel_idx_q == IDX_LAST) begin
                if (mel_loop) begin
                    mel_idx_d = '0;
                end else begin
                    mel_busy_d = 1'b0;
                    mel_idx_d  = '0;
                    mel_done_d = 1'b1;
                end
            end else begin
                mel_idx_d = mel_idx_q + IW'(1);
            end
        end

        if (mel_start) begin
            mel_busy_d = 1'b1;
            mel_idx_d  = '0;
            mel_done_d = 1'b0;
        end

        // Stop overrides a start in the same cycle.
        if (mel_stop) begin
            mel_busy_d = 1'b0;
            mel_idx_d  = '0;
            mel_done_d = 1'b0;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if (alarm_req) begin
            state_d = ST_ALARM;
        end else if (horn_req) begin
            state_d = ST_HORN;
        end else if (mel_busy_d) begin
            state_d = ST_MELODY;
        end
    end

    // A new owner always starts from a full beat.
    always_comb begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if ((state_d != state_q) || beat_tick) begin
            beat_cnt_d = '0;
        end
    end

    always_comb begin
        alarm_hi_d = alarm_hi_q;
        if (state_d == ST_ALARM) begin
            if (state_q != ST_ALARM) begin
                alarm_hi_d = 1'b1;
            end else if (beat_tick) begin
                alarm_hi_d = ~alarm_hi_q;
            end
        end
    end

    always_comb begin
        origin_d  = origin_q;
        tone_en_d = 1'b0;
        unique case (state_d)
            ST_IDLE: begin
                origin_d  = origin_q;
                tone_en_d = 1'b0;
            end
            ST_MELODY: begin
                origin_d  = WIDE'(mel_note);
                tone_en_d = ~is_rest(mel_note);
            end
            ST_HORN: begin
                origin_d  = WIDE'(NOTE_H1);
                tone_en_d = 1'b1;
            end
            ST_ALARM: begin
                origin_d  = alarm_hi_d ? WIDE'(NOTE_H5) : WIDE'(NOTE_M5);
                tone_en_d = 1'b1;
            end
            default: begin
                origin_d  = origin_q;
                tone_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            mel_idx_q  <= '0;
            mel_busy_q <= 1'b0;
            mel_done_q <= 1'b0;
            alarm_hi_q <= 1'b1;
            origin_q   <= '0;
            tone_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            mel_idx_q  <= mel_idx_d;
            mel_busy_q <= mel_busy_d;
            mel_done_q <= mel_done_d;
            alarm_hi_q <= alarm_hi_d;
            origin_q   <= origin_d;
            tone_en_q  <= tone_en_d;
        end
    end

    assign origin   = origin_q;
    assign tone_en  = tone_en_q;
    assign grant    = state_q;
    assign mel_busy = mel_busy_q;
    assign mel_done = mel_done_q;

endmodule

// File: tb/tb_tone_sched.sv
// Directed bench for tone_sched with a 10-cycle beat. Inputs change and
// outputs are sampled 1 ns after the rising clock edge.
module tb_tone_sched;

    logic        clk_50M   = 1'b0;
    logic        rst       = 1'b0;
    logic        alarm_req = 1'b0;
    logic        horn_req  = 1'b0;
    logic        mel_start = 1'b0;
    logic        mel_stop  = 1'b0;
    logic        mel_loop  = 1'b0;
    logic [14:0] origin;
    logic        tone_en;
    logic [1:0]  grant;
    logic        mel_busy;
    logic        mel_done;

    int checks = 0;
    int errors = 0;

    localparam logic [14:0] HORN_V = 15'h6D55;
    localparam logic [14:0] AL_HI  = 15'h738A;
    localparam logic [14:0] AL_LO  = 15'h6715;
    localparam logic [14:0] REST_V = 15'h3FFF;

    // Expected melody, written out note by note.
    localparam logic [14:0] MEL [32] = '{
        15'h6715, 15'h69CD, 15'h6D55, 15'h6F5F, 15'h712F, 15'h6F5F, 15'h6D55, 15'h3FFF,
        15'h6715, 15'h69CD, 15'h6D55, 15'h6D55, 15'h6F5F, 15'h712F, 15'h738A, 15'h3FFF,
        15'h738A, 15'h712F, 15'h6F5F, 15'h6D55, 15'h6C39, 15'h69CD, 15'h6715, 15'h3FFF,
        15'h625F, 15'h6715, 15'h69CD, 15'h6C39, 15'h6D55, 15'h6F5F, 15'h6D55, 15'h3FFF
    };

    tone_sched #(
        .WIDE     (15),
        .BEAT_DIV (10),
        .MEL_LEN  (32)
    ) dut (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .alarm_req (alarm_req),
        .horn_req  (horn_req),
        .mel_start (mel_start),
        .mel_stop  (mel_stop),
        .mel_loop  (mel_loop),
        .origin    (origin),
        .tone_en   (tone_en),
        .grant     (grant),
        .mel_busy  (mel_busy),
        .mel_done  (mel_done)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic step(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_grant",    32'(grant),    32'd0);
        check("rst_tone_en",  32'(tone_en),  32'd0);
        check("rst_origin",   32'(origin),   32'd0);
        check("rst_mel_busy", 32'(mel_busy), 32'd0);
        check("rst_mel_done", 32'(mel_done), 32'd0);
        rst = 1'b1;
        step(1);

        // Full melody without loop
        mel_start = 1'b1;
        step(1);
        mel_start = 1'b0;
        check("play_busy", 32'(mel_busy), 32'd1);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("play_grant_%0d", k),      32'(grant),   32'd1);
            check($sformatf("play_origin_%0d", k),     32'(origin),  32'(MEL[k]));
            check($sformatf("play_tone_en_%0d", k),    32'(tone_en), 32'(MEL[k] != REST_V));
            check($sformatf("play_done_%0d", k),       32'(mel_done), 32'd0);
            step(9);
            check($sformatf("play_origin_end_%0d", k), 32'(origin),  32'(MEL[k]));
            step(1);
        end
        check("end_done",    32'(mel_done), 32'd1);
        check("end_busy",    32'(mel_busy), 32'd0);
        check("end_grant",   32'(grant),    32'd0);
        check("end_tone_en", 32'(tone_en),  32'd0);
        check("end_origin",  32'(origin),   32'(REST_V));
        step(1);
        check("end_done_pulse", 32'(mel_done), 32'd0);

        // Horn preempts melody at index 5, then melody resumes there
        mel_start = 1'b1;
        step(1);
        mel_start = 1'b0;
        step(53);
        check("pre_origin", 32'(origin), 32'(MEL[5]));
        horn_req = 1'b1;
        step(1);
        check("horn_grant",   32'(grant),    32'd2);
        check("horn_origin",  32'(origin),   32'(HORN_V));
        check("horn_tone_en", 32'(tone_en),  32'd1);
        check("horn_busy",    32'(mel_busy), 32'd1);
        step(24);
        check("horn_hold_grant", 32'(grant), 32'd2);
        horn_req = 1'b0;
        step(1);
        check("resume_grant",  32'(grant),  32'd1);
        check("resume_origin", 32'(origin), 32'(MEL[5]));
        step(9);
        check("resume_full_beat", 32'(origin), 32'(MEL[5]));
        step(1);
        check("resume_next", 32'(origin), 32'(MEL[6]));
        check("resume_next_grant", 32'(grant), 32'd1);
        mel_stop = 1'b1;
        step(1);
        mel_stop = 1'b0;
        check("stop_busy",    32'(mel_busy), 32'd0);
        check("stop_grant",   32'(grant),    32'd0);
        check("stop_done",    32'(mel_done), 32'd0);
        check("stop_tone_en", 32'(tone_en),  32'd0);

        // Alarm over horn, alarm phase toggling, then fall back to horn
        alarm_req = 1'b1;
        horn_req  = 1'b1;
        step(1);
        check("alarm_grant",  32'(grant),  32'd3);
        check("alarm_hi_0",   32'(origin), 32'(AL_HI));
        step(9);
        check("alarm_hi_end", 32'(origin), 32'(AL_HI));
        step(1);
        check("alarm_lo",     32'(origin), 32'(AL_LO));
        step(9);
        check("alarm_lo_end", 32'(origin), 32'(AL_LO));
        step(1);
        check("alarm_hi_1",   32'(origin), 32'(AL_HI));
        alarm_req = 1'b0;
        step(1);
        check("alarm_drop_grant",  32'(grant),  32'd2);
        check("alarm_drop_origin", 32'(origin), 32'(HORN_V));
        horn_req = 1'b0;
        step(1);
        check("idle_grant",   32'(grant),   32'd0);
        check("idle_tone_en", 32'(tone_en), 32'd0);
        check("idle_origin",  32'(origin),  32'(HORN_V));

        // Start and stop together while busy
        mel_start = 1'b1;
        step(1);
        mel_start = 1'b0;
        step(5);
        check("both_pre_busy", 32'(mel_busy), 32'd1);
        mel_start = 1'b1;
        mel_stop  = 1'b1;
        step(1);
        mel_start = 1'b0;
        mel_stop  = 1'b0;
        check("both_busy",  32'(mel_busy), 32'd0);
        check("both_grant", 32'(grant),    32'd0);
        check("both_done",  32'(mel_done), 32'd0);
        step(1);
        check("both_done_after", 32'(mel_done), 32'd0);

        // Looping melody wraps without a done pulse
        mel_loop  = 1'b1;
        mel_start = 1'b1;
        step(1);
        mel_start = 1'b0;
        step(310);
        check("loop_last_origin",  32'(origin),  32'(MEL[31]));
        check("loop_last_tone_en", 32'(tone_en), 32'd0);
        step(10);
        check("loop_wrap_origin", 32'(origin),   32'(MEL[0]));
        check("loop_wrap_done",   32'(mel_done), 32'd0);
        check("loop_wrap_busy",   32'(mel_busy), 32'd1);
        check("loop_wrap_grant",  32'(grant),    32'd1);
        step(10);
        check("loop_second", 32'(origin), 32'(MEL[1]));

        // Stop while preempted: melody must not come back
        horn_req = 1'b1;
        step(1);
        check("pstop_horn", 32'(grant), 32'd2);
        mel_stop = 1'b1;
        step(1);
        mel_stop = 1'b0;
        check("pstop_busy",  32'(mel_busy), 32'd0);
        check("pstop_grant", 32'(grant),    32'd2);
        horn_req = 1'b0;
        step(1);
        check("pstop_release_grant", 32'(grant),   32'd0);
        check("pstop_release_tone",  32'(tone_en), 32'd0);
        mel_loop = 1'b0;

        // Asynchronous reset during alarm with a melody pending
        mel_start = 1'b1;
        step(1);
        mel_start = 1'b0;
        step(12);
        alarm_req = 1'b1;
        step(1);
        check("ar_grant", 32'(grant), 32'd3);
        step(4);
        #2;
        rst = 1'b0;
        #1;
        check("ar_grant_async",   32'(grant),    32'd0);
        check("ar_tone_en_async", 32'(tone_en),  32'd0);
        check("ar_origin_async",  32'(origin),   32'd0);
        check("ar_busy_async",    32'(mel_busy), 32'd0);
        check("ar_done_async",    32'(mel_done), 32'd0);
        alarm_req = 1'b0;
        step(1);
        rst = 1'b1;
        step(3);
        check("ar_after_grant", 32'(grant),    32'd0);
        check("ar_after_busy",  32'(mel_busy), 32'd0);
        check("ar_after_tone",  32'(tone_en),  32'd0);
        alarm_req = 1'b1;
        step(1);
        check("ar_phase_hi", 32'(origin), 32'(AL_HI));
        step(10);
        check("ar_phase_lo", 32'(origin), 32'(AL_LO));
        alarm_req = 1'b0;
        step(1);
        check("ar_final_grant", 32'(grant), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_sched.md
TONE_SCHED -- requirements
Module: tone_sched

Interface
REQ-001 Parameters (name, default, meaning): WIDE, 15, tone preset width.
REQ-002 BEAT_DIV, 10000000, clk_50M cycles per beat (5 Hz); benches use 10.
REQ-003 MEL_LEN, 32, melody table entries, one beat each.
REQ-004 Ports (name, direction, width, meaning): clk_50M, in, 1, 50 MHz clock.
REQ-005 rst, in, 1, reset: asynchronous, active-low.
REQ-006 alarm_req, in, 1, level; obstacle alarm request, highest priority.
REQ-007 horn_req, in, 1, level; horn request, middle priority.
REQ-008 mel_start, in, 1, one-cycle pulse; start melody from entry 0.
REQ-009 mel_stop, in, 1, one-cycle pulse; abort melody.
REQ-010 mel_loop, in, 1, level; repeat melody at end.
REQ-011 origin, out, WIDE, preset value for the tone generator.
REQ-012 tone_en, out, 1, 1 = tone generator sounding; 0 = silent.
REQ-013 grant, out, 2, current owner: 0 none, 1 melody, 2 horn, 3 alarm.
REQ-014 mel_busy, out, 1, melody active (playing or preempted).
REQ-015 mel_done, out, 1, one-cycle pulse at natural melody end without loop.

Function
REQ-016 FSM states IDLE, MELODY, HORN, ALARM; grant encodes the state.
REQ-017 Priority: ALARM if alarm_req; else HORN if horn_req; else MELODY if mel_busy; else IDLE. Evaluated every cycle.
REQ-018 All outputs are registered; they reflect inputs sampled on the previous edge (1-cycle latency).
REQ-019 Beat counter counts 0..BEAT_DIV-1 and wraps; beat_tick is asserted on the count BEAT_DIV-1.
REQ-020 On any state change, the beat counter clears to 0 so the new owner gets a full first beat.
REQ-021 IDLE: tone_en=0, origin holds its last value.
REQ-022 HORN: tone_en=1, origin=15'h6D55 constant.
REQ-023 ALARM: tone_en=1, origin alternates 15'h738A / 15'h6715 on each beat_tick, starting with 15'h738A on entry.
REQ-024 MELODY: tone_en=1, origin=table[mel_idx]; mel_idx advances on beat_tick.
REQ-025 When a table entry equals 15'h3FFF it is a rest: tone_en=0 for that beat, and the index still advances.
REQ-026 End of melody (beat_tick at mel_idx=MEL_LEN-1):
- if mel_loop=1: mel_idx wraps to 0.
- else: mel_busy clears, mel_done pulses, and the FSM goes to IDLE unless a higher-priority request is present.
REQ-027 Preemption of MELODY by HORN or ALARM freezes mel_idx; on return to MELODY, playback resumes at the frozen index from beat count 0.
REQ-028 mel_start sets mel_busy and mel_idx=0, also when the melody is already busy or preempted.
REQ-029 mel_stop clears mel_busy and mel_idx, with no mel_done pulse.
REQ-030 If mel_start and mel_stop are asserted in the same cycle, stop wins.
REQ-031 mel_stop while preempted clears the melody, so the FSM does not return to MELODY.
REQ-032 Rising and falling requests in the same cycle resolve purely by REQ-017.

Reset
REQ-033 While rst=0: state=IDLE, origin=0, tone_en=0, grant=0, mel_busy=0, mel_done=0, mel_idx=0, beat counter=0, alarm phase=high.
REQ-034 Reset asserted mid-note or mid-melody aborts immediately; after release, no melody resumes.

Structure
REQ-035 A shared package holds: state encoding, grant codes, note preset constants (M3 625F, M5 6715, M6 69CD, M7 6C39, H1 6D55, H2 6F5F, H3 712F, H5 738A, REST 3FFF).
REQ-036 One sub-module, melody_rom: combinational index-to-preset table of MEL_LEN entries; out-of-range indices return REST.
REQ-037 tone_sched drives the existing tone generator through origin and tone_en, and contains no tone divider itself.

Verification (BEAT_DIV=10)
REQ-038 mel_start pulse, no other requests -> grant=1 and mel_busy=1 next cycle; origin steps through table entries every 10 cycles; mel_done pulses after 32 beats; then grant=0 and tone_en=0.
REQ-039 Melody at idx 5, horn_req asserted for 25 cycles -> grant=2 and origin=6D55 next cycle; on release, grant=1 and origin=table[5] for a full 10 cycles.
REQ-040 alarm_req and horn_req asserted together -> grant=3; origin 738A then 6715 toggling every 10 cycles; drop alarm -> grant=2.
REQ-041 mel_start and mel_stop in the same cycle while busy -> mel_busy=0, no mel_done, grant=0.
REQ-042 mel_loop=1 -> after idx 31, origin returns to table[0] with no mel_done pulse.
REQ-043 rst pulled low mid-melody during an alarm -> all outputs 0 asynchronously; after release, grant=0 until a new request.
